filter_scan_ctrl: RTL and testbench

Sequencer for the threshold-filter datapath. On a start button press it scans every word of the source RAM and copies each word strictly greater than `thresh` into the destination RAM, packed from address 0. It then replays the copied words to the display, holding each one for a fixed number of cycles, and finally asserts `done` with the match count. It sits between the board button/switch inputs and the two RAMs plus the display driver.

---
 rtl/filter_scan_ctrl_pkg.sv | 15 +
 rtl/filter_scan_ctrl_btn_edge.sv | 18 +
 rtl/filter_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_filter_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_scan_ctrl_pkg.sv
// Shared definitions for the threshold-filter sequencer: default widths and FSM states.
package filter_scan_ctrl_pkg;

  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_HOLD_CYC = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_SHOW = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/filter_scan_ctrl_btn_edge.sv
// Rising-edge detector for the start button; emits a one-cycle start pulse.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic start
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign start = btn & ~btn_q;

endmodule

// File: rtl/filter_scan_ctrl.sv
// Threshold-filter sequencer: scans the source RAM, packs matches into the
// destination RAM, replays them to the display, then reports the match count.
module filter_scan_ctrl
  import filter_scan_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] src_data,
  input  logic [DATA_W-1:0] dst_rdata,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_we,
  output logic [DATA_W-1:0] dst_wdata,
  output logic [DATA_W-1:0] disp_val,
  output logic              disp_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_n, dst_n;
  logic [ADDR_W:0]   count_n, count_inc;
  logic [TW-1:0]     timer, timer_n;
  logic              start, gt;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .start (start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      src_addr <= '0;
      dst_addr <= '0;
      count    <= '0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      src_addr <= src_n;
      dst_addr <= dst_n;
      count    <= count_n;
      timer    <= timer_n;
    end
  end

  always_comb begin
    state_n    = state;
    src_n      = src_addr;
    dst_n      = dst_addr;
    count_n    = count;
    timer_n    = timer;
    dst_we     = 1'b0;
    dst_wdata  = '0;
    disp_val   = '0;
    disp_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    gt         = (src_data > thresh);
    count_inc  = count + (ADDR_W + 1)'(gt);

    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          src_n   = '0;
          dst_n   = '0;
          count_n = '0;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        busy    = 1'b1;
        src_n   = src_addr + 1'b1;
        count_n = count_inc;
        if (gt) begin
          dst_we    = 1'b1;
          dst_wdata = src_data;
          dst_n     = dst_addr + 1'b1;
        end
        // Last word: the match decision uses the count including this word.
        if (src_addr == '1) begin
          if (count_inc == '0) begin
            state_n = S_DONE;
          end else begin
            dst_n   = '0;
            timer_n = '0;
            state_n = S_SHOW;
          end
        end
      end
      S_SHOW: begin
        busy       = 1'b1;
        disp_valid = 1'b1;
        disp_val   = dst_rdata;
        if (timer == HOLD_LAST) begin
          if ({1'b0, dst_addr} == count - 1'b1) begin
            state_n = S_DONE;
          end else begin
            dst_n   = dst_addr + 1'b1;
            timer_n = '0;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Scoreboard bench for filter_scan_ctrl with behavioural RAM models.
module tb_filter_scan_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int H  = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b0;
  logic [DW-1:0] thresh = '0;
  logic [DW-1:0] src_data, dst_rdata, dst_wdata, disp_val;
  logic [AW-1:0] src_addr, dst_addr;
  logic          dst_we, disp_valid, busy, done;
  logic [AW:0]   count;

  logic [DW-1:0] src_mem [N];
  logic [DW-1:0] dst_mem [N];

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int cnt; int cyc; } fin_t;

  wr_t           wq[$];
  logic [DW-1:0] dq[$];
  fin_t          fq[$];
  logic [DW-1:0] exp_list[$];

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  filter_scan_ctrl #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .btn(btn), .thresh(thresh),
    .src_data(src_data), .dst_rdata(dst_rdata),
    .src_addr(src_addr), .dst_addr(dst_addr), .dst_we(dst_we),
    .dst_wdata(dst_wdata), .disp_val(disp_val), .disp_valid(disp_valid),
    .busy(busy), .done(done), .count(count)
  );

  assign src_data  = src_mem[src_addr];
  assign dst_rdata = dst_mem[dst_addr];

  always @(posedge clk) if (dst_we) dst_mem[dst_addr] <= dst_wdata;

  // Monitor: pops expectations whenever the DUT writes, displays or finishes.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_excl: busy=%0b done=%0b, required not both", busy, done);
      end
      if (dst_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%0d, required no write", dst_addr, dst_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (dst_addr !== e.a || dst_wdata !== e.d) begin
            errors++;
            $display("FAIL write: addr=%0d data=%0d, required addr=%0d data=%0d",
                     dst_addr, dst_wdata, e.a, e.d);
          end
        end
      end
      if (disp_valid) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_disp: disp_val=%0d, required disp_valid=0", disp_val);
        end else begin
          logic [DW-1:0] v;
          v = dq.pop_front();
          if (disp_val !== v) begin
            errors++;
            $display("FAIL disp_val: got %0d, required %0d", disp_val, v);
          end
        end
      end
      if (busy) busy_cnt++;
      else if (!done) busy_cnt = 0;
      if (done && !prev_done) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: count=%0d, required no done", count);
        end else begin
          fin_t f;
          f = fq.pop_front();
          if (int'(count) != f.cnt || busy_cnt != f.cyc || wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL done: count=%0d busy_cycles=%0d left_wr=%0d left_disp=%0d, required count=%0d busy_cycles=%0d left=0",
                     count, busy_cnt, wq.size(), dq.size(), f.cnt, f.cyc);
          end
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic check_reset(input string name);
    checks++;
    if ({src_addr, dst_addr, count, dst_we, dst_wdata, disp_val, disp_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL %s: src_addr=%0d dst_addr=%0d count=%0d we=%0b wdata=%0d disp=%0d dv=%0b busy=%0b done=%0b, required all 0",
               name, src_addr, dst_addr, count, dst_we, dst_wdata, disp_val, disp_valid, busy, done);
    end
  endtask

  // Reference: matches are the source words strictly above thresh, in address order.
  task automatic build_expect();
    exp_list.delete();
    for (int i = 0; i < N; i++)
      if (int'(src_mem[i]) > int'(thresh)) exp_list.push_back(src_mem[i]);
    for (int j = 0; j < exp_list.size(); j++) begin
      wr_t w;
      w.a = AW'(j);
      w.d = exp_list[j];
      wq.push_back(w);
      for (int k = 0; k < H; k++) dq.push_back(exp_list[j]);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required done=1", name, done, n);
    end
  endtask

  // mode 0: single pulse; 1: btn held through DONE; 2: extra pulse mid-SCAN
  task automatic run(input string name, input int mode);
    fin_t f;
    logic ok;
    build_expect();
    f.cnt = exp_list.size();
    f.cyc = N + f.cnt * H;
    fq.push_back(f);
    @(negedge clk) btn = 1'b1;
    @(negedge clk) if (mode != 1) btn = 1'b0;
    if (mode == 2) begin
      repeat (4) @(negedge clk);
      btn = 1'b1;
      @(negedge clk) btn = 1'b0;
    end
    wait_done(name);
    ok = 1'b1;
    for (int j = 0; j < exp_list.size(); j++)
      if (dst_mem[j] !== exp_list[j]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_dst_mem: dst[0]=%0d, required matches packed from 0 (first=%0d)",
               name, dst_mem[0], (exp_list.size() > 0) ? exp_list[0] : 0);
    end
    if (mode == 1) begin
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL %s_held_btn: busy=%0b done=%0b, required busy=0 done=1", name, busy, done);
      end
      btn = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_mem[i] = '0;
      dst_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N; i++) src_mem[i] = DW'(i);
    thresh = 8'd12;
    run("ramp_t12", 0);
    thresh = 8'd255;
    run("ramp_t255", 0);
    for (int i = 0; i < N; i++) src_mem[i] = 8'd1;
    thresh = 8'd0;
    run("all1_t0", 0);
    for (int i = 0; i < N; i++) src_mem[i] = 8'd12;
    thresh = 8'd12;
    run("all12_t12", 0);
    for (int i = 0; i < N; i++) src_mem[i] = DW'(i * 16 + 3);
    thresh = 8'd100;
    run("held_btn", 1);
    run("midscan_pulse", 2);

    // Reset mid-SCAN: matches at 2 and 4 are written before src_addr reaches 7.
    for (int i = 0; i < N; i++) src_mem[i] = (i == 2 || i == 4) ? 8'd9 : 8'd0;
    thresh = 8'd5;
    wq.push_back('{a: 4'd0, d: 8'd9});
    wq.push_back('{a: 4'd1, d: 8'd9});
    @(negedge clk) btn = 1'b1;
    @(negedge clk) btn = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (busy && src_addr == 4'd7) break;
      @(negedge clk);
    end
    checks++;
    if (!(busy && src_addr == 4'd7 && wq.size() == 0)) begin
      errors++;
      $display("FAIL pre_reset: busy=%0b src_addr=%0d pending_writes=%0d, required busy=1 src_addr=7 pending=0",
               busy, src_addr, wq.size());
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_scan_reset");
    rst = 1'b0;
    wq.delete();
    dq.delete();
    @(negedge clk);
    run("rescan_after_reset", 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) src_mem[i] = DW'($urandom_range(0, 255));
      thresh = DW'($urandom_range(0, 255));
      run("random", 0);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
